srio_lane_sync_ctrl: RTL and testbench

- Per-lane receive lane-synchronisation controller for the SRIO VIP serial PHY model.
- Watches the 10-bit parallel receive code-group stream from one lane (one element of rx_pdata), detects K28.5 commas and decoder-flagged invalid code-groups.
- Runs the acquire / sync / error-tolerance state machine and reports lane_sync to the lane-alignment and port-init logic.
- One instance per lane, 16 max.

---
 rtl/srio_lane_sync_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_srio_lane_sync_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_lane_sync_ctrl.sv
// srio_lane_sync_ctrl
// Per-lane receive synchronisation controller for one SRIO serial lane.
// Watches the 10-bit code-group stream, counts K28.5 commas to acquire
// sync, tolerates sparse decoder errors while synchronised, and reports
// lane_sync plus acquire/loss pulses and a saturating error count.
module srio_lane_sync_ctrl #(
  parameter int unsigned COMMA_CNT = 127,
  parameter int unsigned VALID_CNT = 255,
  parameter int unsigned INV_LIMIT = 3
) (
  input  logic        sim_clk,
  input  logic        srio_rst,
  input  logic        lane_en,
  input  logic        cg_valid,
  input  logic [0:9]  rx_cg,
  input  logic        code_err,
  input  logic        err_clr,
  output logic        lane_sync,
  output logic [1:0]  sync_state,
  output logic        sync_acq,
  output logic        sync_lost,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_NO_SYNC  = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_SYNC     = 2'd2,
    ST_SYNC_ERR = 2'd3
  } state_t;

  // Code-groups are written a..j left to right; with [0:9] the leftmost
  // literal bit lands on index 0 ('a').
  localparam logic [0:9] LP_K28_5_RDN = 10'b0011111010;
  localparam logic [0:9] LP_K28_5_RDP = 10'b1100000101;

  // Counter values at which the next qualifying event completes the run.
  localparam logic [7:0] LP_K_LAST = 8'(COMMA_CNT - 1);
  localparam logic [7:0] LP_V_LAST = 8'(VALID_CNT - 1);
  localparam logic [1:0] LP_I_LAST = 2'(INV_LIMIT - 1);

  state_t      r_state;
  logic [7:0]  r_k_cnt;
  logic [7:0]  r_v_cnt;
  logic [1:0]  r_i_cnt;
  logic [15:0] r_err_cnt;
  logic        r_sync_acq;
  logic        r_sync_lost;

  state_t      w_state_nxt;
  logic [7:0]  w_k_nxt;
  logic [7:0]  w_v_nxt;
  logic [1:0]  w_i_nxt;
  logic [15:0] w_err_nxt;
  logic        w_acq_nxt;
  logic        w_lost_nxt;
  logic        w_err_inc;
  logic        w_comma;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

  // A decoder error disqualifies a comma-shaped code-group.
  assign w_comma = ~code_err & ((rx_cg == LP_K28_5_RDN) | (rx_cg == LP_K28_5_RDP));

  // Next-state, counter and pulse decode; qualified code-groups only.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k_cnt;
    w_v_nxt     = r_v_cnt;
    w_i_nxt     = r_i_cnt;
    w_acq_nxt   = 1'b0;
    w_lost_nxt  = 1'b0;
    w_err_inc   = 1'b0;
    if (!lane_en) begin
      w_state_nxt = ST_NO_SYNC;
      w_k_nxt     = 8'd0;
      w_v_nxt     = 8'd0;
      w_i_nxt     = 2'd0;
    end else if (cg_valid) begin
      unique case (r_state)
        ST_NO_SYNC: begin
          if (w_comma) begin
            w_state_nxt = ST_ACQUIRE;
            w_k_nxt     = 8'd1;
          end else begin
            w_k_nxt = 8'd0;
            w_v_nxt = 8'd0;
            w_i_nxt = 2'd0;
          end
        end
        ST_ACQUIRE: begin
          if (code_err) begin
            w_state_nxt = ST_NO_SYNC;
            w_k_nxt     = 8'd0;
          end else if (w_comma) begin
            if (r_k_cnt == LP_K_LAST) begin
              w_state_nxt = ST_SYNC;
              w_acq_nxt   = 1'b1;
              w_k_nxt     = 8'd0;
            end else begin
              w_k_nxt = r_k_cnt + 8'd1;
            end
          end
        end
        ST_SYNC: begin
          if (code_err) begin
            w_state_nxt = ST_SYNC_ERR;
            w_i_nxt     = 2'd1;
            w_v_nxt     = 8'd0;
            w_err_inc   = 1'b1;
          end
        end
        ST_SYNC_ERR: begin
          if (code_err) begin
            w_err_inc = 1'b1;
            if (r_i_cnt == LP_I_LAST) begin
              w_state_nxt = ST_NO_SYNC;
              w_lost_nxt  = 1'b1;
              w_k_nxt     = 8'd0;
              w_v_nxt     = 8'd0;
              w_i_nxt     = 2'd0;
            end else begin
              w_i_nxt = r_i_cnt + 2'd1;
              w_v_nxt = 8'd0;
            end
          end else if (r_v_cnt == LP_V_LAST) begin
            // A full run of good code-groups forgives one error.
            w_v_nxt = 8'd0;
            w_i_nxt = r_i_cnt - 2'd1;
            if (r_i_cnt == 2'd1) begin
              w_state_nxt = ST_SYNC;
            end
          end else begin
            w_v_nxt = r_v_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  // Error counter: held while the lane is disabled, clear beats increment.
  always_comb begin
    w_err_nxt = r_err_cnt;
    if (lane_en) begin
      if (err_clr) begin
        w_err_nxt = 16'd0;
      end else if (w_err_inc) begin
        w_err_nxt = sat_inc16(r_err_cnt);
      end
    end
  end

  // State, counters and pulse registers with asynchronous reset.
  always_ff @(posedge sim_clk or posedge srio_rst) begin
    if (srio_rst) begin
      r_state     <= ST_NO_SYNC;
      r_k_cnt     <= 8'd0;
      r_v_cnt     <= 8'd0;
      r_i_cnt     <= 2'd0;
      r_err_cnt   <= 16'd0;
      r_sync_acq  <= 1'b0;
      r_sync_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k_cnt     <= w_k_nxt;
      r_v_cnt     <= w_v_nxt;
      r_i_cnt     <= w_i_nxt;
      r_err_cnt   <= w_err_nxt;
      r_sync_acq  <= w_acq_nxt;
      r_sync_lost <= w_lost_nxt;
    end
  end

  assign lane_sync  = (r_state == ST_SYNC) || (r_state == ST_SYNC_ERR);
  assign sync_state = r_state;
  assign sync_acq   = r_sync_acq;
  assign sync_lost  = r_sync_lost;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_srio_lane_sync_ctrl.sv
// Scoreboard bench for srio_lane_sync_ctrl: the driver steps a behavioural
// model for every clock and queues the expected outputs; a monitor pops
// one entry per rising edge and compares all outputs.
module tb_srio_lane_sync_ctrl;

  localparam int COMMA_CNT = 127;
  localparam int VALID_CNT = 255;
  localparam int INV_LIMIT = 3;
  localparam logic [0:9] K_RDN = 10'b0011111010;
  localparam logic [0:9] K_RDP = 10'b1100000101;

  logic        sim_clk = 1'b0;
  logic        srio_rst;
  logic        lane_en;
  logic        cg_valid;
  logic [0:9]  rx_cg;
  logic        code_err;
  logic        err_clr;
  logic        lane_sync;
  logic [1:0]  sync_state;
  logic        sync_acq;
  logic        sync_lost;
  logic [15:0] err_cnt;

  srio_lane_sync_ctrl #(
    .COMMA_CNT(COMMA_CNT),
    .VALID_CNT(VALID_CNT),
    .INV_LIMIT(INV_LIMIT)
  ) dut (
    .sim_clk   (sim_clk),
    .srio_rst  (srio_rst),
    .lane_en   (lane_en),
    .cg_valid  (cg_valid),
    .rx_cg     (rx_cg),
    .code_err  (code_err),
    .err_clr   (err_clr),
    .lane_sync (lane_sync),
    .sync_state(sync_state),
    .sync_acq  (sync_acq),
    .sync_lost (sync_lost),
    .err_cnt   (err_cnt)
  );

  always #5 sim_clk = ~sim_clk;

  typedef struct {
    logic        ls;
    logic [1:0]  st;
    logic        acq;
    logic        lost;
    logic [15:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: state named by number (0 idle, 1 acquiring, 2 locked,
  // 3 locked with errors), counters as plain integers.
  int m_st, m_k, m_v, m_i, m_err;
  bit m_acq, m_lost;
  bit rd_pos = 1'b0;

  function automatic void model_reset();
    m_st = 0; m_k = 0; m_v = 0; m_i = 0; m_err = 0;
    m_acq = 1'b0; m_lost = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit v, input logic [0:9] cg,
                                     input bit ce, input bit clr);
    bit inc;
    bit comma;
    inc    = 1'b0;
    m_acq  = 1'b0;
    m_lost = 1'b0;
    if (!en) begin
      m_st = 0; m_k = 0; m_v = 0; m_i = 0;
      return;
    end
    if (v) begin
      comma = !ce && (cg == K_RDN || cg == K_RDP);
      case (m_st)
        0: if (comma) begin m_st = 1; m_k = 1; end
        1: begin
          if (ce) begin m_st = 0; m_k = 0; end
          else if (comma) begin
            if (m_k + 1 == COMMA_CNT) begin m_st = 2; m_acq = 1'b1; m_k = 0; end
            else m_k = m_k + 1;
          end
        end
        2: if (ce) begin m_st = 3; m_i = 1; m_v = 0; inc = 1'b1; end
        default: begin
          if (ce) begin
            inc = 1'b1;
            if (m_i + 1 == INV_LIMIT) begin
              m_st = 0; m_lost = 1'b1; m_k = 0; m_v = 0; m_i = 0;
            end else begin
              m_i = m_i + 1; m_v = 0;
            end
          end else if (m_v + 1 == VALID_CNT) begin
            m_v = 0; m_i = m_i - 1;
            if (m_i == 0) m_st = 2;
          end else begin
            m_v = m_v + 1;
          end
        end
      endcase
    end
    if (clr) m_err = 0;
    else if (inc) m_err = (m_err >= 65535) ? 65535 : m_err + 1;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.ls   = (m_st >= 2);
    e.st   = 2'(m_st);
    e.acq  = m_acq;
    e.lost = m_lost;
    e.err  = 16'(m_err);
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [0:9] rand_d();
    logic [0:9] x;
    do x = 10'($urandom_range(0, 1023)); while (x == K_RDN || x == K_RDP);
    return x;
  endfunction

  function automatic logic [0:9] next_comma();
    rd_pos = ~rd_pos;
    return rd_pos ? K_RDN : K_RDP;
  endfunction

  // One stimulus cycle: inputs change just after the falling edge.
  task automatic drive(input bit en, input bit v, input logic [0:9] cg,
                       input bit ce, input bit clr);
    @(negedge sim_clk); #1;
    srio_rst = 1'b0; lane_en = en; cg_valid = v; rx_cg = cg;
    code_err = ce; err_clr = clr;
    model_step(en, v, cg, ce, clr);
    push_exp();
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, next_comma(), 1'b0, 1'b0);
  endtask

  task automatic send_valid(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, rand_d(), 1'b0, 1'b0);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sim_clk); #1;
      srio_rst = 1'b1;
      model_reset();
      push_exp();
    end
  endtask

  // Reset between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    @(negedge sim_clk); #1;
    srio_rst = 1'b1;
    #1;
    check("async_rst_lane_sync", 16'(lane_sync), 16'd0);
    check("async_rst_sync_state", 16'(sync_state), 16'd0);
    check("async_rst_sync_acq", 16'(sync_acq), 16'd0);
    check("async_rst_sync_lost", 16'(sync_lost), 16'd0);
    check("async_rst_err_cnt", err_cnt, 16'd0);
    model_reset();
    push_exp();
  endtask

  // Preload the error counter near saturation; the force spans one edge so
  // the register itself captures the preloaded value before release.
  task automatic preload_err();
    @(negedge sim_clk); #1;
    srio_rst = 1'b0; lane_en = 1'b1; cg_valid = 1'b0; code_err = 1'b0; err_clr = 1'b0;
    force dut.r_err_cnt = 16'hFFFE;
    model_step(1'b1, 1'b0, rx_cg, 1'b0, 1'b0);
    m_err = 16'hFFFE;
    push_exp();
    @(posedge sim_clk); #2;
    release dut.r_err_cnt;
  endtask

  // Monitor: one expected entry per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge sim_clk); #1;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty: got no expectation, expected one at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("lane_sync", 16'(lane_sync), 16'(e.ls));
        check("sync_state", 16'(sync_state), 16'(e.st));
        check("sync_acq", 16'(sync_acq), 16'(e.acq));
        check("sync_lost", 16'(sync_lost), 16'(e.lost));
        check("err_cnt", err_cnt, e.err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    bit aborted;
    srio_rst = 1'b1; lane_en = 1'b0; cg_valid = 1'b0; rx_cg = 10'd0;
    code_err = 1'b0; err_clr = 1'b0;
    model_reset();
    push_exp();
    hold_reset(2);

    // Acquire: 126 commas leave lane_sync low, the 127th locks.
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    send_commas(COMMA_CNT);
    send_valid(5);

    // Error forgiveness: one error then a full run of good code-groups.
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
    send_valid(VALID_CNT);
    send_valid(3);

    // Sync loss: three errors separated by ten good code-groups.
    drive(1'b1, 1'b1, rand_d(), 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
      if (n < 2) send_valid(10);
    end
    send_valid(3);

    // Acquire abort: 100 commas, an error, then a fresh full run.
    send_commas(100);
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
    send_commas(COMMA_CNT);
    send_valid(2);

    // Gaps: unqualified cycles interleaved; an errored comma aborts once.
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    lane_en = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    q = 0;
    aborted = 1'b0;
    while (q < COMMA_CNT) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 1'b1, next_comma(), 1'b0, 1'b0);
        q++;
      end else begin
        drive(1'b1, 1'b0, ($urandom_range(0, 1) == 1) ? K_RDN : rand_d(),
              1'($urandom_range(0, 1)), 1'b0);
      end
      if (q == 60 && !aborted) begin
        aborted = 1'b1;
        drive(1'b1, 1'b1, K_RDP, 1'b1, 1'b0);
        q = 0;
      end
    end
    send_valid(2);

    // Lane disable while locked: drop to idle, no loss pulse, count held.
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
    drive(1'b0, 1'b1, rand_d(), 1'b1, 1'b0);
    drive(1'b0, 1'b1, K_RDN, 1'b0, 1'b0);
    send_valid(2);

    // Saturation and clear priority.
    send_commas(COMMA_CNT);
    preload_err();
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b0);
    drive(1'b1, 1'b1, rand_d(), 1'b1, 1'b1);
    send_valid(2);

    // Asynchronous reset in the middle of acquisition.
    send_commas(50);
    mid_reset();
    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    send_commas(10);

    // Random traffic: sparse errors so acquisition can complete.
    for (int n = 0; n < 1500; n++) begin
      bit en, v, ce, clr;
      en  = ($urandom_range(0, 999) < 995);
      v   = ($urandom_range(0, 99) < 85);
      ce  = ($urandom_range(0, 999) < 3);
      clr = en && v && ($urandom_range(0, 99) < 2);
      drive(en, v, ($urandom_range(0, 9) < 7) ? next_comma() : rand_d(), ce, clr);
    end
    // Random traffic: dense errors to exercise the error-tolerance path.
    send_commas(COMMA_CNT);
    for (int n = 0; n < 800; n++) begin
      bit en, v, ce, clr;
      en  = ($urandom_range(0, 999) < 997);
      v   = ($urandom_range(0, 99) < 90);
      ce  = ($urandom_range(0, 99) < 4);
      clr = en && v && ($urandom_range(0, 99) < 1);
      drive(en, v, ($urandom_range(0, 9) < 5) ? next_comma() : rand_d(), ce, clr);
    end

    drive(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    @(posedge sim_clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
